// File: rtl/ram_bytewise_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared definitions for the byte-writable RAM slice.
//   - state_t         : clear-engine FSM state (IDLE, CLEAR)
//   - DEF_* constants : default parameter values used by ram_bytewise and
//                       ram_clear_ctrl
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_READ_FIRST = 0;
    localparam int unsigned DEF_INIT_CLEAR = 1;

endpackage

// File: rtl/ram_clear_ctrl.sv
// ---------------------------------------------------------------------------
// ram_clear_ctrl
//   Zero-fill engine for ram_bytewise. Walks the clear counter over every
//   address, issuing one zero write per cycle, then returns to IDLE.
//
//   Parameters
//     ADDR_W      address width (depth = 2**ADDR_W)
//     INIT_CLEAR  1: reset leaves the engine in CLEAR so the array is
//                 zero-filled right after reset release; 0: reset to IDLE
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     clear_start  one-cycle pulse, starts a zero-fill when IDLE
//     clr_we       zero-write strobe towards the array
//     clr_addr     address being zeroed this cycle
//     busy         high while in CLEAR
// ---------------------------------------------------------------------------
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INIT_CLEAR = DEF_INIT_CLEAR
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W:0]   w_cnt_inc;

    // The counter carries one extra bit: the increment past the last address
    // sets the MSB, which is the terminal condition without any wrap compare.
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc[ADDR_W]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy     = (r_state == CLEAR);
    // No array writes while reset is held, even though the state may sit in CLEAR.
    assign clr_we   = busy & rst_n;
    assign clr_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_bytewise.sv
// ---------------------------------------------------------------------------
// ram_bytewise
//   Single-clock, one-write/one-read RAM with per-byte write enables, a
//   registered read port (1-cycle latency) and a built-in zero-fill engine.
//
//   Parameters
//     DATA_W      word width, multiple of 8
//     ADDR_W      address width, depth = 2**ADDR_W
//     READ_FIRST  same-address read/write: 1 = old word, 0 = merged new word
//     INIT_CLEAR  1 = zero-fill automatically after reset
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     wr_valid/addr/data/be write request, byte enables per 8-bit lane
//     rd_valid/addr         read request
//     rd_rsp_valid/rd_data  read response, one cycle after acceptance;
//                           rd_data holds when no response
//     ready                 requests accepted only while high (not clearing)
//     clear_start           pulse that starts a zero-fill
//     busy                  zero-fill in progress
// ---------------------------------------------------------------------------
module ram_bytewise
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned READ_FIRST = DEF_READ_FIRST,
    parameter int unsigned INIT_CLEAR = DEF_INIT_CLEAR
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_rsp_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ready,
    input  logic                clear_start,
    output logic                busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_collide;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd_word;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rd_data;

    ram_clear_ctrl #(
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_start (clear_start),
        .clr_we      (w_clr_we),
        .clr_addr    (w_clr_addr),
        .busy        (w_busy)
    );

    assign w_ready   = ~w_busy;
    assign w_wr_acc  = wr_valid & w_ready & rst_n;
    assign w_rd_acc  = rd_valid & w_ready;
    assign w_collide = w_wr_acc & (wr_addr == rd_addr);

    // Stored word with the enabled lanes replaced by write data. Serves both
    // as the value written back and as the write-first bypass word.
    always_comb begin
        w_wr_merged = r_mem[wr_addr];
        for (int unsigned k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
                w_wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if ((READ_FIRST == 0) && w_collide) begin
            w_rd_word = w_wr_merged;
        end
    end

    // Array has no reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rsp_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_rsp_valid = r_rsp_valid;
    assign rd_data      = r_rd_data;
    assign ready        = w_ready;
    assign busy         = w_busy;

endmodule
